mem_port_arbiter: RTL and testbench

Arbiter that shares the single data port of the unified RAM between instruction fetch (IF) and the memory stage (MEM). One request is issued to the RAM per cycle. The memory stage has priority, bounded by a starvation limit that guarantees fetch progress. Read data returns a fixed number of cycles later, and a tag pipeline steers each response back to its owner. The block sits between the pipeline stages and the RAM port.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_resp_tag_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-RAM port arbiter.
//   mem_owner_e         : owner tag carried alongside each in-flight read
//   MEM_ARB_MAX_LATENCY : deepest RAM read latency the tag pipeline supports
//   STARVE_CNT_W        : width of the fetch starvation counter
//   sat_inc()           : saturating increment used by the starvation counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } mem_owner_e;

    localparam int MEM_ARB_MAX_LATENCY = 4;
    localparam int STARVE_CNT_W        = 4;

    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] val,
        input logic [STARVE_CNT_W-1:0] lim
    );
        return (val >= lim) ? lim : val + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch request port, the memory-stage request port and the RAM
// data port seen by the arbiter.
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            responses and the RAM access)
//   master : environment side (requesters plus RAM)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    // Instruction fetch port
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;

    // Memory-stage port
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_be_i;
    logic        mem_gnt_o;
    logic        mem_rvalid_o;
    logic [31:0] mem_rdata_o;

    // RAM port
    logic        ram_en_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
        input  ram_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
        output ram_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
    );

endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// -----------------------------------------------------------------------------
// resp_tag_pipe
// LATENCY-stage shift register of owner tags. A tag entering at tag_i appears
// at tag_o exactly LATENCY cycles later, lining up with the RAM read data.
//   clk_i : clock
//   clr_i : synchronous clear, empties every stage to OWN_NONE
//   tag_i : owner of the access issued this cycle
//   tag_o : owner of the read data returning this cycle
// -----------------------------------------------------------------------------
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  mem_owner_e tag_i,
    output mem_owner_e tag_o
);

    mem_owner_e stage_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified-RAM data port between instruction fetch (IF) and
// the memory stage (MEM). One access per cycle, zero-cycle arbitration. MEM
// wins ties until IF has lost STARVE_LIMIT times in a row, then IF wins once.
// Read responses are steered back to their owner by a tag pipeline matching
// the RAM read latency; writes produce no response.
//   clk_i : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : request/grant/response ports of both requesters and the RAM port
// Parameters:
//   LATENCY      : RAM read latency in cycles (1..4)
//   STARVE_LIMIT : max consecutive MEM grants while IF waits (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    // Out-of-range parameters are clamped to the supported range.
    localparam int TAG_DEPTH = (LATENCY < 1) ? 1 :
                               (LATENCY > MEM_ARB_MAX_LATENCY) ? MEM_ARB_MAX_LATENCY : LATENCY;
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    if_gnt, mem_gnt;
    logic                    if_rvalid, mem_rvalid;
    mem_owner_e              tag_in, tag_out;

    // Grant selection: MEM has priority unless IF has been starved to the limit.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (bus.if_req_i && bus.mem_req_i) begin
                if (starve_cnt_q >= LIMIT) begin
                    if_gnt = 1'b1;
                end else begin
                    mem_gnt = 1'b1;
                end
            end else begin
                if_gnt  = bus.if_req_i;
                mem_gnt = bus.mem_req_i;
            end
        end
    end

    // Counts MEM wins while IF is waiting; any gap in the IF request restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req_i || if_gnt) begin
            starve_cnt_d = '0;
        end else if (mem_gnt) begin
            starve_cnt_d = sat_inc(starve_cnt_q, LIMIT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // RAM access mux; idle cycles drive an all-zero access.
    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_be_o    = '0;
        if (if_gnt) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_addr_o = bus.if_addr_i;
            bus.ram_be_o   = 4'hF;
        end else if (mem_gnt) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.mem_we_i;
            bus.ram_addr_o  = bus.mem_addr_i;
            bus.ram_wdata_o = bus.mem_wdata_i;
            bus.ram_be_o    = bus.mem_be_i;
        end
    end

    assign bus.if_gnt_o  = if_gnt;
    assign bus.mem_gnt_o = mem_gnt;

    // Only reads need a response slot; writes complete at grant.
    always_comb begin
        tag_in = OWN_NONE;
        if (if_gnt) begin
            tag_in = OWN_IF;
        end else if (mem_gnt && !bus.mem_we_i) begin
            tag_in = OWN_MEM;
        end
    end

    resp_tag_pipe #(
        .LATENCY (TAG_DEPTH)
    ) u_resp_tag_pipe (
        .clk_i (clk_i),
        .clr_i (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // The last stage still holds pre-reset tags during the first reset cycle,
    // so responses are masked while rst is high.
    assign if_rvalid  = !rst && (tag_out == OWN_IF);
    assign mem_rvalid = !rst && (tag_out == OWN_MEM);

    assign bus.if_rvalid_o  = if_rvalid;
    assign bus.if_rdata_o   = if_rvalid  ? bus.ram_rdata_i : '0;
    assign bus.mem_rvalid_o = mem_rvalid;
    assign bus.mem_rdata_o  = mem_rvalid ? bus.ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared cycle by cycle against a behavioural model of requesters, RAM and
// response ordering.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 3;
    localparam int SL  = 4;

    typedef struct {
        int          due;
        int          own;   // 1 = IF, 2 = MEM
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .LATENCY      (LAT),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester state
    bit          rst_v;
    bit          if_pend;
    logic [31:0] if_a;
    bit          mem_pend;
    bit          mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;

    // Model state
    int          wait_cnt;
    bit          g_if, g_mem;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];

    // RAM environment (reacts to what the DUT actually drives)
    rd_t         rq[$];
    logic [31:0] ram_mem [logic [31:0]];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    // Drive this cycle's inputs, predict and compare every output.
    task automatic drive_check();
        logic        e_en, e_we, e_ifv, e_memv;
        logic [31:0] e_addr, e_wd, e_ifd, e_memd;
        logic [3:0]  e_be;
        rst             = rst_v;
        bus.if_req_i    = if_pend;
        bus.if_addr_i   = if_a;
        bus.mem_req_i   = mem_pend;
        bus.mem_we_i    = mem_we;
        bus.mem_addr_i  = mem_a;
        bus.mem_wdata_i = mem_wd;
        bus.mem_be_i    = mem_be;
        while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        if (rq.size() > 0 && rq[0].due == cyc) begin
            bus.ram_rdata_i = rq[0].data;
            void'(rq.pop_front());
        end else begin
            bus.ram_rdata_i = $urandom;
        end
        #1;
        g_if  = 1'b0;
        g_mem = 1'b0;
        if (!rst_v) begin
            if (if_pend && mem_pend) begin
                if (wait_cnt >= SL) g_if = 1'b1;
                else                g_mem = 1'b1;
            end else begin
                g_if  = if_pend;
                g_mem = mem_pend;
            end
        end
        e_en   = g_if | g_mem;
        e_we   = g_mem & mem_we;
        e_addr = g_if ? if_a : (g_mem ? mem_a : 32'h0);
        e_wd   = g_mem ? mem_wd : 32'h0;
        e_be   = g_if ? 4'hF : (g_mem ? mem_be : 4'h0);
        e_ifv  = 1'b0;
        e_memv = 1'b0;
        e_ifd  = 32'h0;
        e_memd = 32'h0;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (!rst_v) begin
                if (exp_q[0].own == 1) begin
                    e_ifv = 1'b1;
                    e_ifd = exp_q[0].data;
                end else begin
                    e_memv = 1'b1;
                    e_memd = exp_q[0].data;
                end
            end
            void'(exp_q.pop_front());
        end
        check_val("if_gnt",     32'(bus.if_gnt_o),     32'(g_if));
        check_val("mem_gnt",    32'(bus.mem_gnt_o),    32'(g_mem));
        check_val("ram_en",     32'(bus.ram_en_o),     32'(e_en));
        check_val("ram_we",     32'(bus.ram_we_o),     32'(e_we));
        check_val("ram_addr",   bus.ram_addr_o,        e_addr);
        check_val("ram_wdata",  bus.ram_wdata_o,       e_wd);
        check_val("ram_be",     32'(bus.ram_be_o),     32'(e_be));
        check_val("if_rvalid",  32'(bus.if_rvalid_o),  32'(e_ifv));
        check_val("if_rdata",   bus.if_rdata_o,        e_ifd);
        check_val("mem_rvalid", 32'(bus.mem_rvalid_o), 32'(e_memv));
        check_val("mem_rdata",  bus.mem_rdata_o,       e_memd);
        check_val("starve_cnt", 32'(dut.starve_cnt_q), 32'(wait_cnt));
    endtask

    // Update RAM environment and model, then move to the next cycle.
    task automatic advance();
        if (bus.ram_en_o) begin
            if (bus.ram_we_o) ram_mem[bus.ram_addr_o] = merge(ram_rd(bus.ram_addr_o), bus.ram_wdata_o, bus.ram_be_o);
            else              rq.push_back('{cyc + LAT, ram_rd(bus.ram_addr_o)});
        end
        if (rst_v) exp_q.delete();
        if (g_if)               exp_q.push_back('{cyc + LAT, 1, ref_rd(if_a)});
        if (g_mem && !mem_we)   exp_q.push_back('{cyc + LAT, 2, ref_rd(mem_a)});
        if (g_mem && mem_we)    ref_mem[mem_a] = merge(ref_rd(mem_a), mem_wd, mem_be);
        if (rst_v || !if_pend || g_if) wait_cnt = 0;
        else if (g_mem)                wait_cnt = (wait_cnt + 1 > SL) ? SL : wait_cnt + 1;
        if (g_if)  if_pend  = 1'b0;
        if (g_mem) mem_pend = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        drive_check();
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_mem(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_pend = 1'b1;
        mem_we   = we;
        mem_a    = a;
        mem_wd   = d;
        mem_be   = be;
    endtask

    task automatic set_if(input logic [31:0] a);
        if_pend = 1'b1;
        if_a    = a;
    endtask

    initial begin
        rst_v = 1'b1; if_pend = 1'b0; mem_pend = 1'b0; mem_we = 1'b0;
        if_a = '0; mem_a = '0; mem_wd = '0; mem_be = '0; wait_cnt = 0;
        g_if = 1'b0; g_mem = 1'b0;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
        bus.mem_addr_i = '0; bus.mem_wdata_i = '0; bus.mem_be_i = '0; bus.ram_rdata_i = '0;
        ram_mem[32'h0] = 32'h11; ram_mem[32'h4] = 32'h22; ram_mem[32'h8] = 32'h33;
        ref_mem[32'h0] = 32'h11; ref_mem[32'h4] = 32'h22; ref_mem[32'h8] = 32'h33;
        @(posedge clk);
        #1;

        // Reset, with requests pending to prove grants stay low
        set_if(32'h40);
        set_mem(1'b0, 32'h44, 32'h0, 4'hF);
        idle(2);
        if_pend = 1'b0; mem_pend = 1'b0;
        rst_v = 1'b0;
        idle(2);

        // IF-only stream
        set_if(32'h0); cycle();
        set_if(32'h4); cycle();
        set_if(32'h8); cycle();
        idle(LAT + 1);

        // Both requesting continuously: MEM x4 then IF
        for (int k = 0; k < 15; k++) begin
            if (!if_pend)  set_if(32'h100 + 32'(4 * k));
            if (!mem_pend) set_mem(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF);
            drive_check();
            check_val("starve_pattern", 32'(bus.if_gnt_o), 32'((k % 5) == 4));
            advance();
        end
        if_pend = 1'b0; mem_pend = 1'b0;
        idle(LAT + 1);

        // Partial store, no response expected
        set_mem(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011); cycle();
        idle(LAT + 1);

        // Interleaved IF / MEM / IF reads
        set_if(32'h0); cycle();
        set_mem(1'b0, 32'h100, 32'h0, 4'hF); cycle();
        set_if(32'h8); cycle();
        idle(LAT + 1);

        // Reset while a MEM read is in flight
        set_mem(1'b0, 32'h4, 32'h0, 4'hF); cycle();
        rst_v = 1'b1; cycle();
        rst_v = 1'b0; idle(LAT + 1);

        // Write then read back the same word
        set_mem(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF); cycle();
        set_mem(1'b0, 32'h40, 32'h0, 4'hF); cycle();
        idle(LAT + 1);

        // Saturated counter clears when IF withdraws
        set_if(32'h20);
        for (int k = 0; k < SL; k++) begin
            set_mem(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF);
            cycle();
        end
        if_pend = 1'b0;
        set_mem(1'b0, 32'h310, 32'h0, 4'hF); cycle();
        set_if(32'h24); set_mem(1'b0, 32'h314, 32'h0, 4'hF); cycle();
        if_pend = 1'b0; mem_pend = 1'b0;
        idle(LAT + 1);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            rst_v = ($urandom_range(0, 99) == 0);
            if (!if_pend && $urandom_range(0, 9) < 6) set_if({26'h0, 4'($urandom_range(0, 15)), 2'b00});
            if (!mem_pend && $urandom_range(0, 9) < 5)
                set_mem(($urandom_range(0, 9) < 4), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                        $urandom, 4'($urandom_range(0, 15)));
            cycle();
        end
        rst_v = 1'b0; if_pend = 1'b0; mem_pend = 1'b0;
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
